// File: rtl/rf_pkg.sv
// Shared widths and the operand-fetch response bundle.
package rf_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  typedef struct packed {
    logic [RF_DATA_W-1:0] a;
    logic [RF_DATA_W-1:0] b;
    logic [RF_ADDR_W-1:0] rd;
    logic                 rd_en;
  } rsp_t;

endpackage

// File: rtl/rf_operand_fetch_if.sv
// Issue request / operand response handshake bundle.
interface rf_operand_fetch_if #(
  parameter int data_w = 32,
  parameter int addr_w = 5
);

  logic              req_valid;
  logic              req_ready;
  logic [addr_w-1:0] req_ra;
  logic [addr_w-1:0] req_rb;
  logic [addr_w-1:0] req_rd;
  logic              req_rd_en;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [data_w-1:0] rsp_a;
  logic [data_w-1:0] rsp_b;
  logic [addr_w-1:0] rsp_rd;
  logic              rsp_rd_en;

  modport master (
    output req_valid, req_ra, req_rb,
    output req_rd, req_rd_en, rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_a, rsp_b, rsp_rd, rsp_rd_en
  );

  modport slave (
    input  req_valid, req_ra, req_rb,
    input  req_rd, req_rd_en, rsp_ready,
    output req_ready, rsp_valid,
    output rsp_a, rsp_b, rsp_rd, rsp_rd_en
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Busy bit per register: set on issue, cleared on writeback.
module rf_scoreboard #(
  parameter int addr_w = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [addr_w-1:0] set_idx,
  input  logic              clr_en,
  input  logic [addr_w-1:0] clr_idx,
  input  logic [addr_w-1:0] idx_a,
  input  logic [addr_w-1:0] idx_b,
  input  logic [addr_w-1:0] idx_d,
  output logic              busy_a,
  output logic              busy_b,
  output logic              busy_d
);

  localparam int N = 2 ** addr_w;

  logic [N-1:0] busy;

  // WAW stalls keep set and clear off the same bit in one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      if (clr_en) busy[clr_idx] <= 1'b0;
      if (set_en) busy[set_idx] <= 1'b1;
    end
  end

  assign busy_a = busy[idx_a];
  assign busy_b = busy[idx_b];
  assign busy_d = busy[idx_d];

endmodule

// File: rtl/rf_operand_fetch.sv
// Operand fetch / writeback controller for a 2R1W register file.
// Optional same-cycle writeback forwarding: define RF_BYPASS_EN.
module rf_operand_fetch
  import rf_pkg::*;
#(
  parameter int data_w = RF_DATA_W,
  parameter int addr_w = RF_ADDR_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  rf_operand_fetch_if.slave bus,
  input  logic              wb_valid,
  input  logic [addr_w-1:0] wb_rd,
  input  logic [data_w-1:0] wb_data,
  output logic [addr_w-1:0] RA,
  output logic [addr_w-1:0] RB,
  input  logic [data_w-1:0] DA,
  input  logic [data_w-1:0] DB,
  output logic [addr_w-1:0] RW,
  output logic              WE,
  output logic [data_w-1:0] DW
);

  logic        busy_a;
  logic        busy_b;
  logic        busy_d;
  logic        raw;
  logic        waw;
  logic        ready;
  logic        issue;
  logic [data_w-1:0] op_a;
  logic [data_w-1:0] op_b;
  rsp_t        rsp_q;
  logic        valid_q;

  assign RA = bus.req_ra;
  assign RB = bus.req_rb;
  assign WE = wb_valid;
  assign RW = wb_rd;
  assign DW = wb_data;

  rf_scoreboard #(.addr_w(addr_w)) u_sb (
    .clk     (CLK),
    .rst_n   (RST_N),
    .set_en  (issue && bus.req_rd_en),
    .set_idx (bus.req_rd),
    .clr_en  (wb_valid),
    .clr_idx (wb_rd),
    .idx_a   (bus.req_ra),
    .idx_b   (bus.req_rb),
    .idx_d   (bus.req_rd),
    .busy_a  (busy_a),
    .busy_b  (busy_b),
    .busy_d  (busy_d)
  );

`ifdef RF_BYPASS_EN
  logic fwd_a;
  logic fwd_b;

  assign fwd_a = wb_valid && (wb_rd == bus.req_ra);
  assign fwd_b = wb_valid && (wb_rd == bus.req_rb);
  assign op_a  = fwd_a ? wb_data : DA;
  assign op_b  = fwd_b ? wb_data : DB;
  assign raw   = (busy_a && !fwd_a) || (busy_b && !fwd_b);
`else
  assign op_a  = DA;
  assign op_b  = DB;
  assign raw   = busy_a || busy_b;
`endif

  assign waw   = bus.req_rd_en && busy_d;
  assign ready = RST_N && (!valid_q || bus.rsp_ready)
              && !raw && !waw;
  assign issue = bus.req_valid && ready;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      valid_q <= 1'b0;
      rsp_q   <= '0;
    end else if (issue) begin
      valid_q     <= 1'b1;
      rsp_q.a     <= op_a;
      rsp_q.b     <= op_b;
      rsp_q.rd    <= bus.req_rd;
      rsp_q.rd_en <= bus.req_rd_en;
    end else if (bus.rsp_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_a     = rsp_q.a;
  assign bus.rsp_b     = rsp_q.b;
  assign bus.rsp_rd    = rsp_q.rd;
  assign bus.rsp_rd_en = rsp_q.rd_en;

endmodule

// File: tb/tb_rf_operand_fetch.sv
// Directed bench for rf_operand_fetch with a behavioural 2R1W RF.
// Honours RF_BYPASS_EN for the RAW-stall timing.
module tb_rf_operand_fetch;

  logic        CLK;
  logic        RST_N;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  RA;
  logic [4:0]  RB;
  logic [31:0] DA;
  logic [31:0] DB;
  logic [4:0]  RW;
  logic        WE;
  logic [31:0] DW;

  logic [31:0] rf [32] = '{default: 32'h0};

  int errs   = 0;
  int checks = 0;

  rf_operand_fetch_if #(.data_w(32), .addr_w(5)) bus ();

  rf_operand_fetch dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .bus      (bus.slave),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .RA       (RA),
    .RB       (RB),
    .DA       (DA),
    .DB       (DB),
    .RW       (RW),
    .WE       (WE),
    .DW       (DW)
  );

  always @(posedge CLK) if (WE) rf[RW] <= DW;
  assign DA = rf[RA];
  assign DB = rf[RB];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic req(input logic [4:0] ra, input logic [4:0] rb,
                     input logic [4:0] rd, input logic en);
    bus.req_valid = 1'b1;
    bus.req_ra    = ra;
    bus.req_rb    = rb;
    bus.req_rd    = rd;
    bus.req_rd_en = en;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] d);
    wb_valid = 1'b1;
    wb_rd    = rd;
    wb_data  = d;
  endtask

  initial begin
    RST_N = 1'b0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    bus.req_valid = 1'b0; bus.req_ra = '0; bus.req_rb = '0;
    bus.req_rd = '0; bus.req_rd_en = 1'b0;
    bus.rsp_ready = 1'b1;

    // reset state
    tick();
    req(5'd3, 5'd4, 5'd0, 1'b0);
    #1;
    chk("rst_ready", {31'b0, bus.req_ready}, 32'd0);
    chk("rst_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst_a", bus.rsp_a, 32'd0);
    chk("rst_rden", {31'b0, bus.rsp_rd_en}, 32'd0);
    chk("rst_we", {31'b0, WE}, 32'd0);
    bus.req_valid = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;

    // preload through the writeback port
    wb(5'd3, 32'h11);
    #1;
    chk("wb_we", {31'b0, WE}, 32'd1);
    chk("wb_dw", DW, 32'h11);
    chk("wb_rw", {27'b0, RW}, 32'd3);
    tick();
    wb(5'd4, 32'h22);
    tick();
    wb_valid = 1'b0;

    // basic issue
    req(5'd3, 5'd4, 5'd0, 1'b0);
    chk("basic_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("basic_RA", {27'b0, RA}, 32'd3);
    tick();
    bus.req_valid = 1'b0;
    chk("basic_valid", {31'b0, bus.rsp_valid}, 32'd1);
    chk("basic_a", bus.rsp_a, 32'h11);
    chk("basic_b", bus.rsp_b, 32'h22);
    tick();
    chk("basic_drain", {31'b0, bus.rsp_valid}, 32'd0);

    // RAW stall on r5
    req(5'd0, 5'd0, 5'd5, 1'b1);
    tick();
    chk("raw_rd", {27'b0, bus.rsp_rd}, 32'd5);
    chk("raw_rden", {31'b0, bus.rsp_rd_en}, 32'd1);
    req(5'd5, 5'd3, 5'd0, 1'b0);
    chk("raw_stall0", {31'b0, bus.req_ready}, 32'd0);
    tick();
    chk("raw_stall1", {31'b0, bus.req_ready}, 32'd0);
    wb(5'd5, 32'hABCD);
`ifdef RF_BYPASS_EN
    chk("raw_wbcyc", {31'b0, bus.req_ready}, 32'd1);
    tick();
    wb_valid = 1'b0;
    bus.req_valid = 1'b0;
`else
    chk("raw_wbcyc", {31'b0, bus.req_ready}, 32'd0);
    tick();
    wb_valid = 1'b0;
    chk("raw_after", {31'b0, bus.req_ready}, 32'd1);
    tick();
    bus.req_valid = 1'b0;
`endif
    chk("raw_valid", {31'b0, bus.rsp_valid}, 32'd1);
    chk("raw_a", bus.rsp_a, 32'hABCD);
    chk("raw_b", bus.rsp_b, 32'h11);
    tick();

    // WAW on r7
    req(5'd0, 5'd0, 5'd7, 1'b1);
    tick();
    req(5'd3, 5'd4, 5'd7, 1'b1);
    chk("waw_stall", {31'b0, bus.req_ready}, 32'd0);
    tick();
    wb(5'd7, 32'h77);
    chk("waw_wbcyc", {31'b0, bus.req_ready}, 32'd0);
    tick();
    wb_valid = 1'b0;
    chk("waw_after", {31'b0, bus.req_ready}, 32'd1);
    tick();
    bus.req_valid = 1'b0;
    chk("waw_rd", {27'b0, bus.rsp_rd}, 32'd7);
    chk("waw_a", bus.rsp_a, 32'h11);
    wb(5'd7, 32'h78);
    tick();
    wb_valid = 1'b0;

    // backpressure
    bus.rsp_ready = 1'b0;
    req(5'd3, 5'd4, 5'd0, 1'b0);
    tick();
    req(5'd4, 5'd3, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_ready", {31'b0, bus.req_ready}, 32'd0);
      chk("bp_valid", {31'b0, bus.rsp_valid}, 32'd1);
      chk("bp_a", bus.rsp_a, 32'h11);
      chk("bp_b", bus.rsp_b, 32'h22);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_release", {31'b0, bus.req_ready}, 32'd1);
    tick();
    bus.req_valid = 1'b0;
    chk("bp_a2", bus.rsp_a, 32'h22);
    chk("bp_b2", bus.rsp_b, 32'h11);
    tick();

    // stray writeback to idle r9
    wb(5'd9, 32'h55);
    tick();
    wb_valid = 1'b0;
    chk("stray_rf", rf[9], 32'h55);
    req(5'd9, 5'd9, 5'd9, 1'b1);
    chk("stray_ready", {31'b0, bus.req_ready}, 32'd1);
    tick();
    bus.req_valid = 1'b0;
    chk("stray_a", bus.rsp_a, 32'h55);
    chk("stray_b", bus.rsp_b, 32'h55);
    tick();

    // async reset in the middle of a RAW stall
    bus.rsp_ready = 1'b0;
    req(5'd0, 5'd0, 5'd5, 1'b1);
    tick();
    req(5'd5, 5'd5, 5'd0, 1'b0);
    chk("ar_stall", {31'b0, bus.req_ready}, 32'd0);
    #2;
    RST_N = 1'b0;
    #1;
    chk("ar_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("ar_rd", {27'b0, bus.rsp_rd}, 32'd0);
    chk("ar_a", bus.rsp_a, 32'd0);
    chk("ar_ready", {31'b0, bus.req_ready}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    bus.rsp_ready = 1'b1;
    #1;
    chk("ar_free", {31'b0, bus.req_ready}, 32'd1);
    tick();
    bus.req_valid = 1'b0;
    chk("ar_issue", {31'b0, bus.rsp_valid}, 32'd1);
    chk("ar_opa", bus.rsp_a, 32'hABCD);
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
